vpu_opnd_fetch_ctrl: RTL and testbench
======================================

# vpu_opnd_fetch_ctrl

Operand-fetch controller between the VPU instruction decoder and the four-bank operand SRAM. It accepts one decoded instruction's 1–3 source addresses and splits each address into a bank ID and a row address. It issues bank reads, serialising sources that collide on the same bank, and collects the 512-bit read data. It then presents the assembled operand bundle to the vector-lane execution stage over a valid/ready handshake.

## Interface
- `SRC_CNT`, default 3: maximum number of source operands per instruction.
- `BANK_CNT`, default 4: number of SRAM banks (power of 2).
- `BANK_DEPTH_LG2`, default 10: row-address width.
- `DATA_WIDTH`, default 512: bank data width (power of 2).
- `ADDR_WIDTH`, default 32: operand address width.
- `clk`  in  1  sole clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid_i`  in  1  instruction valid.
- `req_ready_o`  out  1  controller can accept an instruction.
- `req_src_cnt_i`  in  2  number of sources, 0..3.
- `req_src_addr_i`  in  `SRC_CNT*ADDR_WIDTH`  source *i* is at `[i*32 +: 32]`.
- `sram_rd_en_o`  out  `BANK_CNT`  per-bank read enable.
- `sram_raddr_o`  out  `BANK_CNT*BANK_DEPTH_LG2`  per-bank row address.
- `sram_rdata_i`  in  `BANK_CNT*DATA_WIDTH`  per-bank read data, valid 1 cycle after `rd_en`.
- `opnd_valid_o`  out  1  operand bundle valid.
- `opnd_ready_i`  in  1  execution stage accepts the bundle.
- `opnd_data_o`  out  `SRC_CNT*DATA_WIDTH`  operand *i* is at `[i*512 +: 512]`.
- `busy_o`  out  1  state is not IDLE.

## Operation
- Address split:
  - bank = `addr[10:9]`
  - row = `addr[20:11]`
  - `addr[31:21]` and `addr[8:0]` are ignored.
- `src_cnt > SRC_CNT` is clamped to `SRC_CNT`.
- States:
  - **IDLE**
    - `req_ready_o` = 1.
    - On `req_valid_i & req_ready_o`: latch the addresses, set the pending mask to the lowest `src_cnt` bits, and clear the operand registers.
    - Go to ISSUE if `src_cnt` ≠ 0, else go to VALID.
  - **ISSUE**
    - Scan pending sources in index order 0→2.
    - A source is granted if no lower-index pending source targets the same bank.
    - For each granted source: assert `sram_rd_en_o[bank]`, drive its row onto `sram_raddr_o`, clear its pending bit, and record it in the in-flight mask.
    - When the pending mask after this cycle's grants is empty, go to DRAIN.
  - **DRAIN**
    - No reads are issued.
    - Capture the last in-flight data, then go to VALID.
  - **VALID**
    - `opnd_valid_o` = 1; `opnd_data_o` is held stable.
    - On `opnd_ready_i`, go to IDLE.
- Capture rule: in every cycle, each source flagged in-flight in the previous cycle loads `sram_rdata_i[its bank]` into its operand slot.
- Unused slots (index ≥ `src_cnt`) output zero.
- At most one read per bank per cycle; all three rows of a 3-way conflict complete in 3 ISSUE cycles.

## Timing
- Reset values:
  - `req_ready_o` = 1, `opnd_valid_o` = 0, `busy_o` = 0.
  - `sram_rd_en_o` = 0, `sram_raddr_o` = 0, `opnd_data_o` = 0.
  - State = IDLE, all masks cleared.
- `sram_rd_en_o` and `sram_raddr_o` are combinational from state and pending mask; all other outputs are registered.
- Request accepted at the edge ending cycle T:
  - No bank conflict: ISSUE in T+1, DRAIN in T+2, `opnd_valid_o` first high in T+3.
  - Each extra serialised round adds 1 cycle (worst case valid in T+5).
  - `src_cnt` = 0: valid in T+1.
- No overlap: the next request is accepted no earlier than the cycle after the output handshake.
- Backpressure: `opnd_valid_o` and `opnd_data_o` hold indefinitely while `opnd_ready_i` = 0.
- Reset mid-operation: immediately return to reset values. In-flight SRAM data is discarded; no read is reissued.

## Configuration
- `VPU_OPND_DUP_MERGE_EN`
  - Defined: in ISSUE, a pending source whose bank and row both equal those of a lower-index granted source is granted in the same cycle without an extra read, and receives the same data.
  - Undefined: duplicates are treated as ordinary bank conflicts and serialised.

## Test plan
- No conflict:
  - Stimulus: `src_cnt`=3, addresses 0x800/0xA00/0xC00.
  - Required: `rd_en`=4'b0111, all rows=1 in T+1; valid in T+3 with bank0/1/2 data in slots 0/1/2.
- 3-way conflict:
  - Stimulus: addresses 0x200/0xA00/0x1200.
  - Required: `rd_en`=4'b0010 for 3 cycles with rows 0,1,2; valid in T+5; slots in source order.
- Partial bundle:
  - Stimulus: `src_cnt`=1, address 0x600.
  - Required: one read on bank3 row0; valid in T+3; slots 1–2 are zero.
- Backpressure:
  - Stimulus: hold `opnd_ready_i`=0 for 5 cycles.
  - Required: valid and data stable, `req_ready_o`=0; IDLE in the cycle after ready rises.
- Reset mid-ISSUE:
  - Stimulus: assert `rst_n`=0 during round 2 of the conflict case.
  - Required: all outputs at reset values immediately; a new request is accepted normally afterwards.
- Duplicate merge:
  - Stimulus: addresses 0xA00/0xA00/0x800, with and without `VPU_OPND_DUP_MERGE_EN`.
  - Required with the macro: 1 ISSUE cycle, valid in T+3.
  - Required without the macro: 2 ISSUE cycles, valid in T+4.
  - Either build: slots 0 and 1 hold equal data.

Source files
------------

// File: rtl/vpu_opnd_fetch_ctrl_if.sv
// Handshake and SRAM bundle between the decoder, the operand SRAM and the lane execution stage.
// Ports: request side (req_*), bank read side (sram_*), operand bundle side (opnd_*), busy flag.
// Modports: master = the fetch controller, slave = its environment (decoder, SRAM, execution stage).
interface vpu_opnd_fetch_ctrl_if #(
   parameter int SRC_CNT        = 3,
   parameter int BANK_CNT       = 4,
   parameter int BANK_DEPTH_LG2 = 10,
   parameter int DATA_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 32
);
   logic                               req_valid_i;
   logic                               req_ready_o;
   logic [1:0]                         req_src_cnt_i;
   logic [SRC_CNT*ADDR_WIDTH-1:0]      req_src_addr_i;
   logic [BANK_CNT-1:0]                sram_rd_en_o;
   logic [BANK_CNT*BANK_DEPTH_LG2-1:0] sram_raddr_o;
   logic [BANK_CNT*DATA_WIDTH-1:0]     sram_rdata_i;
   logic                               opnd_valid_o;
   logic                               opnd_ready_i;
   logic [SRC_CNT*DATA_WIDTH-1:0]      opnd_data_o;
   logic                               busy_o;

   modport master (
      input  req_valid_i, req_src_cnt_i, req_src_addr_i, sram_rdata_i, opnd_ready_i,
      output req_ready_o, sram_rd_en_o, sram_raddr_o, opnd_valid_o, opnd_data_o, busy_o
   );

   modport slave (
      output req_valid_i, req_src_cnt_i, req_src_addr_i, sram_rdata_i, opnd_ready_i,
      input  req_ready_o, sram_rd_en_o, sram_raddr_o, opnd_valid_o, opnd_data_o, busy_o
   );
endinterface

// File: rtl/vpu_opnd_fetch_ctrl.sv
// Operand fetch: splits 1-3 source addresses into bank/row, issues bank reads (serialising bank
// conflicts), collects read data and presents the operand bundle. Latency: valid 3 cycles after
// accept without conflict, +1 per extra round, 1 cycle for zero sources. Backpressure: bundle held
// while opnd_ready_i is low; no new request is accepted until the bundle is taken.
// Ports: clk, rst_n (async active-low), bus (vpu_opnd_fetch_ctrl_if.master).
// Optional macro VPU_OPND_DUP_MERGE_EN: sources with identical bank and row share one read.
module vpu_opnd_fetch_ctrl #(
   parameter int SRC_CNT        = 3,
   parameter int BANK_CNT       = 4,
   parameter int BANK_DEPTH_LG2 = 10,
   parameter int DATA_WIDTH     = 512,
   parameter int ADDR_WIDTH     = 32
) (
   input logic                   clk,
   input logic                   rst_n,
   vpu_opnd_fetch_ctrl_if.master bus
);

   localparam int BANK_LG2 = $clog2(BANK_CNT);
   localparam int BANK_LSB = 9;
   localparam int ROW_LSB  = BANK_LSB + BANK_LG2;

`ifdef VPU_OPND_DUP_MERGE_EN
   localparam bit MERGE_EN = 1'b1;
`else
   localparam bit MERGE_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, VALID} state_t;

   state_t                    state_q, state_d;
   logic [SRC_CNT-1:0]        pend_q;
   logic [SRC_CNT-1:0]        infl_q;
   logic [BANK_LG2-1:0]       bank_q [SRC_CNT];
   logic [BANK_DEPTH_LG2-1:0] row_q  [SRC_CNT];
   logic [DATA_WIDTH-1:0]     opnd_q [SRC_CNT];

   logic [SRC_CNT-1:0]        req_pend;
   logic [SRC_CNT-1:0]        grant;
   logic [SRC_CNT-1:0]        blocked;
   logic [SRC_CNT-1:0]        merged;
   logic [BANK_CNT-1:0]       rd_en;
   logic [BANK_DEPTH_LG2-1:0] raddr_arr [BANK_CNT];
   logic [DATA_WIDTH-1:0]     rdata_arr [BANK_CNT];

   // Only the bank and row fields of each address matter; the rest is deliberately dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^bus.req_src_addr_i;

   for (genvar b = 0; b < BANK_CNT; b++) begin : g_bank
      assign rdata_arr[b] = bus.sram_rdata_i[b*DATA_WIDTH +: DATA_WIDTH];
      assign bus.sram_raddr_o[b*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2] = raddr_arr[b];
   end

   for (genvar s = 0; s < SRC_CNT; s++) begin : g_slot
      assign bus.opnd_data_o[s*DATA_WIDTH +: DATA_WIDTH] = opnd_q[s];
   end

   // Lowest src_cnt bits set. Because the index never reaches SRC_CNT, a count above
   // SRC_CNT naturally saturates to all sources.
   always_comb begin
      req_pend = '0;
      for (int i = 0; i < SRC_CNT; i++) begin
         req_pend[i] = (i < int'(bus.req_src_cnt_i));
      end
   end

   // A pending source is blocked by any lower-index pending source on the same bank. With
   // merging, a same-bank same-row match against a granted lower source overrides the block.
   always_comb begin
      grant   = '0;
      blocked = '0;
      merged  = '0;
      for (int i = 0; i < SRC_CNT; i++) begin
         for (int j = 0; j < i; j++) begin
            if (pend_q[j] && (bank_q[j] == bank_q[i])) begin
               blocked[i] = 1'b1;
               if (MERGE_EN && grant[j] && (row_q[j] == row_q[i])) begin
                  merged[i] = 1'b1;
               end
            end
         end
         grant[i] = (state_q == ISSUE) && pend_q[i] && (!blocked[i] || merged[i]);
      end
   end

   // Granted sources never disagree on a bank's row, so merged grants rewrite identical values.
   always_comb begin
      rd_en = '0;
      for (int b = 0; b < BANK_CNT; b++) begin
         raddr_arr[b] = '0;
      end
      for (int i = 0; i < SRC_CNT; i++) begin
         if (grant[i]) begin
            rd_en[bank_q[i]]     = 1'b1;
            raddr_arr[bank_q[i]] = row_q[i];
         end
      end
   end

   assign bus.sram_rd_en_o = rd_en;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.req_valid_i) state_d = (req_pend == '0) ? VALID : ISSUE;
         ISSUE:   if ((pend_q & ~grant) == '0) state_d = DRAIN;
         DRAIN:   state_d = VALID;
         VALID:   if (bus.opnd_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pend_q  <= '0;
         infl_q  <= '0;
         for (int i = 0; i < SRC_CNT; i++) begin
            bank_q[i] <= '0;
            row_q[i]  <= '0;
            opnd_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         // grant is zero outside ISSUE, so the in-flight mask empties by itself in DRAIN.
         infl_q  <= grant;
         if ((state_q == IDLE) && bus.req_valid_i) begin
            pend_q <= req_pend;
            for (int i = 0; i < SRC_CNT; i++) begin
               bank_q[i] <= bus.req_src_addr_i[i*ADDR_WIDTH + BANK_LSB +: BANK_LG2];
               row_q[i]  <= bus.req_src_addr_i[i*ADDR_WIDTH + ROW_LSB +: BANK_DEPTH_LG2];
               opnd_q[i] <= '0;
            end
         end else begin
            pend_q <= pend_q & ~grant;
            // SRAM data arrives one cycle after the read, so capture keys off last cycle's grants.
            for (int i = 0; i < SRC_CNT; i++) begin
               if (infl_q[i]) begin
                  opnd_q[i] <= rdata_arr[bank_q[i]];
               end
            end
         end
      end
   end

   assign bus.req_ready_o  = (state_q == IDLE);
   assign bus.opnd_valid_o = (state_q == VALID);
   assign bus.busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_vpu_opnd_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_vpu_opnd_fetch_ctrl;
   localparam int SRC_CNT = 3, BANK_CNT = 4, BANK_DEPTH_LG2 = 10, DATA_WIDTH = 512, ADDR_WIDTH = 32;
   localparam int RW = BANK_CNT*BANK_DEPTH_LG2;

   typedef struct packed {
      logic [SRC_CNT*DATA_WIDTH-1:0] data;
      int                            lat;
      int                            t_acc;
      int                            id;
   } exp_opnd_t;

   typedef struct packed {
      logic [BANK_CNT-1:0] en;
      logic [RW-1:0]       raddr;
      int                  id;
   } exp_rd_t;

   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   tid = 0;

   exp_opnd_t q_opnd[$];
   exp_rd_t   q_rd[$];

   vpu_opnd_fetch_ctrl_if #(
      .SRC_CNT(SRC_CNT), .BANK_CNT(BANK_CNT), .BANK_DEPTH_LG2(BANK_DEPTH_LG2),
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) bus ();

   vpu_opnd_fetch_ctrl #(
      .SRC_CNT(SRC_CNT), .BANK_CNT(BANK_CNT), .BANK_DEPTH_LG2(BANK_DEPTH_LG2),
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DATA_WIDTH-1:0] pat(input int b, input int row);
      logic [31:0] w;
      w = 32'hC000_005A | (32'(b) << 24) | (32'(row) << 8);
      return {16{w}};
   endfunction

   function automatic logic [DATA_WIDTH-1:0] junk(input int b);
      logic [31:0] w;
      w = 32'hDEAD_0000 | 32'(b);
      return {16{w}};
   endfunction

   function automatic logic [RW-1:0] mk_raddr(input int r0, input int r1, input int r2, input int r3);
      return {10'(r3), 10'(r2), 10'(r1), 10'(r0)};
   endfunction

   // SRAM model: data one cycle after rd_en, recognisable junk otherwise.
   logic [DATA_WIDTH-1:0] rdata_arr [BANK_CNT];
   always @(posedge clk) begin
      for (int b = 0; b < BANK_CNT; b++) begin
         rdata_arr[b] <= bus.sram_rd_en_o[b]
            ? pat(b, int'(bus.sram_raddr_o[b*BANK_DEPTH_LG2 +: BANK_DEPTH_LG2])) : junk(b);
      end
   end
   for (genvar b = 0; b < BANK_CNT; b++) begin : g_rd
      assign bus.sram_rdata_i[b*DATA_WIDTH +: DATA_WIDTH] = rdata_arr[b];
   end

   task automatic chk(input string name, input logic [DATA_WIDTH-1:0] act, input logic [DATA_WIDTH-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Operand monitor: pops one expectation per bundle, then checks stability while held.
   logic [SRC_CNT*DATA_WIDTH-1:0] held;
   bit seen = 0;
   always @(negedge clk) begin : mon_opnd
      exp_opnd_t e;
      if (rst_n) begin
         if (!bus.opnd_valid_o) begin
            seen = 0;
         end else if (!seen) begin
            if (q_opnd.size() == 0) begin
               checks++; errors++;
               $display("FAIL opnd_unexpected: bundle presented with nothing expected");
            end else begin
               e = q_opnd.pop_front();
               chk($sformatf("t%0d_lat", e.id), DATA_WIDTH'(cyc - e.t_acc), DATA_WIDTH'(e.lat));
               for (int s = 0; s < SRC_CNT; s++)
                  chk($sformatf("t%0d_slot%0d", e.id, s), bus.opnd_data_o[s*DATA_WIDTH +: DATA_WIDTH],
                      e.data[s*DATA_WIDTH +: DATA_WIDTH]);
            end
            held = bus.opnd_data_o;
            seen = 1;
         end else begin
            for (int s = 0; s < SRC_CNT; s++)
               chk($sformatf("hold_slot%0d", s), bus.opnd_data_o[s*DATA_WIDTH +: DATA_WIDTH],
                   held[s*DATA_WIDTH +: DATA_WIDTH]);
         end
      end
   end

   // Read monitor: each cycle with any rd_en must match the next expected read round.
   always @(negedge clk) begin : mon_rd
      exp_rd_t r;
      if (rst_n && (bus.sram_rd_en_o != '0)) begin
         if (q_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_unexpected: rd_en=%b raddr=%0h", bus.sram_rd_en_o, bus.sram_raddr_o);
         end else begin
            r = q_rd.pop_front();
            chk($sformatf("t%0d_rd_en", r.id), DATA_WIDTH'(bus.sram_rd_en_o), DATA_WIDTH'(r.en));
            chk($sformatf("t%0d_raddr", r.id), DATA_WIDTH'(bus.sram_raddr_o), DATA_WIDTH'(r.raddr));
         end
      end
   end

   task automatic push_rd(input logic [BANK_CNT-1:0] en, input logic [RW-1:0] raddr);
      exp_rd_t r;
      r.en = en; r.raddr = raddr; r.id = tid;
      q_rd.push_back(r);
   endtask

   task automatic send(input logic [1:0] cnt, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input int lat, input logic [DATA_WIDTH-1:0] d0,
                       input logic [DATA_WIDTH-1:0] d1, input logic [DATA_WIDTH-1:0] d2);
      exp_opnd_t e;
      int n;
      @(negedge clk); #1;
      bus.req_valid_i    = 1'b1;
      bus.req_src_cnt_i  = cnt;
      bus.req_src_addr_i = {a2, a1, a0};
      n = 0;
      while (!bus.req_ready_o && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      chk($sformatf("t%0d_accept", tid), DATA_WIDTH'(bus.req_ready_o), DATA_WIDTH'(1));
      if (bus.req_ready_o) begin
         e.data = {d2, d1, d0}; e.lat = lat; e.t_acc = cyc; e.id = tid;
         q_opnd.push_back(e);
      end
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q_opnd.size() != 0 || q_rd.size() != 0 || bus.busy_o) && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      chk($sformatf("t%0d_done", tid), DATA_WIDTH'(n < 100), DATA_WIDTH'(1));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req_ready"}, DATA_WIDTH'(bus.req_ready_o), DATA_WIDTH'(1));
      chk({tag, "_valid"}, DATA_WIDTH'(bus.opnd_valid_o), DATA_WIDTH'(0));
      chk({tag, "_busy"}, DATA_WIDTH'(bus.busy_o), DATA_WIDTH'(0));
      chk({tag, "_rd_en"}, DATA_WIDTH'(bus.sram_rd_en_o), DATA_WIDTH'(0));
      chk({tag, "_raddr"}, DATA_WIDTH'(bus.sram_raddr_o), DATA_WIDTH'(0));
      for (int s = 0; s < SRC_CNT; s++)
         chk($sformatf("%s_data%0d", tag, s), bus.opnd_data_o[s*DATA_WIDTH +: DATA_WIDTH], '0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      int n;
      rst_n              = 1'b0;
      bus.req_valid_i    = 1'b0;
      bus.req_src_cnt_i  = '0;
      bus.req_src_addr_i = '0;
      bus.opnd_ready_i   = 1'b1;
      #12;
      chk_reset_vals("reset");
      @(negedge clk); #1;
      rst_n = 1'b1;

      // 1: no conflict, banks 0/1/2 row 1
      tid = 1;
      push_rd(4'b0111, mk_raddr(1, 1, 1, 0));
      send(2'd3, 32'h800, 32'hA00, 32'hC00, 3, pat(0, 1), pat(1, 1), pat(2, 1));
      wait_idle();

      // 2: 3-way conflict on bank 1, rows 0/1/2
      tid = 2;
      push_rd(4'b0010, mk_raddr(0, 0, 0, 0));
      push_rd(4'b0010, mk_raddr(0, 1, 0, 0));
      push_rd(4'b0010, mk_raddr(0, 2, 0, 0));
      send(2'd3, 32'h200, 32'hA00, 32'h1200, 5, pat(1, 0), pat(1, 1), pat(1, 2));
      wait_idle();

      // 3: partial bundle, unused addresses ignored
      tid = 3;
      push_rd(4'b1000, mk_raddr(0, 0, 0, 0));
      send(2'd1, 32'h600, 32'h800, 32'hC00, 3, pat(3, 0), '0, '0);
      wait_idle();

      // 4: backpressure, with ignored high/low address bits set
      tid = 4;
      bus.opnd_ready_i = 1'b0;
      push_rd(4'b1101, mk_raddr(1, 0, 'h200, 3));
      send(2'd3, 32'h0000_1E00, 32'hFFE0_09FF, 32'h0010_0400, 3, pat(3, 3), pat(0, 1), pat(2, 'h200));
      n = 0;
      while (!bus.opnd_valid_o && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      chk("bp_valid_seen", DATA_WIDTH'(bus.opnd_valid_o), DATA_WIDTH'(1));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk("bp_valid_hold", DATA_WIDTH'(bus.opnd_valid_o), DATA_WIDTH'(1));
         chk("bp_req_ready", DATA_WIDTH'(bus.req_ready_o), DATA_WIDTH'(0));
      end
      bus.opnd_ready_i = 1'b1;
      @(negedge clk); #1;
      chk("bp_idle_busy", DATA_WIDTH'(bus.busy_o), DATA_WIDTH'(0));
      chk("bp_idle_req_ready", DATA_WIDTH'(bus.req_ready_o), DATA_WIDTH'(1));
      chk("bp_idle_valid", DATA_WIDTH'(bus.opnd_valid_o), DATA_WIDTH'(0));
      wait_idle();

      // 5: zero sources, bundle of zeros one cycle after accept
      tid = 5;
      send(2'd0, 32'h800, 32'hA00, 32'hC00, 1, '0, '0, '0);
      wait_idle();

      // 6: reset during round 2 of the conflict case, then a normal request
      tid = 6;
      push_rd(4'b0010, mk_raddr(0, 0, 0, 0));
      push_rd(4'b0010, mk_raddr(0, 1, 0, 0));
      push_rd(4'b0010, mk_raddr(0, 2, 0, 0));
      send(2'd3, 32'h200, 32'hA00, 32'h1200, 5, pat(1, 0), pat(1, 1), pat(1, 2));
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      chk("midrst_rounds_left", DATA_WIDTH'(q_rd.size()), DATA_WIDTH'(1));
      q_rd.delete();
      q_opnd.delete();
      @(negedge clk); #1;
      rst_n = 1'b1;
      tid = 7;
      push_rd(4'b0011, mk_raddr(1, 1, 0, 0));
      send(2'd2, 32'h800, 32'hA00, 32'h1200, 3, pat(0, 1), pat(1, 1), '0);
      wait_idle();

      // 8: duplicate source address
      tid = 8;
`ifdef VPU_OPND_DUP_MERGE_EN
      push_rd(4'b0011, mk_raddr(1, 1, 0, 0));
      send(2'd3, 32'hA00, 32'hA00, 32'h800, 3, pat(1, 1), pat(1, 1), pat(0, 1));
`else
      push_rd(4'b0011, mk_raddr(1, 1, 0, 0));
      push_rd(4'b0010, mk_raddr(0, 1, 0, 0));
      send(2'd3, 32'hA00, 32'hA00, 32'h800, 4, pat(1, 1), pat(1, 1), pat(0, 1));
`endif
      wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
